// File: rtl/risc_v_multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded instruction fields and ALU flags
// flow into the controller, strobes and mux selects flow out.
//   master : controller side (samples fields/flags, drives controls)
//   slave  : datapath side
interface risc_v_multicycle_controller_if;
    logic [6:0] op;          // instr[6:0]
    logic [2:0] func3;       // instr[14:12]
    logic       func7;       // instr[30]
    logic       zero;        // ALU result == 0
    logic       neg;         // ALU result sign bit

    logic       PCWrite;     // PC register enable
    logic       adrSrc;      // memory address: 0=PC, 1=Result
    logic       memWrite;    // memory write strobe
    logic       IRWrite;     // IR/OldPC enable
    logic       regWrite;    // register file write strobe
    logic [1:0] resultSrc;   // 0=ALUOut 1=Data 2=ALUResult 3=ImmExt
    logic [1:0] ALUSrcA;     // 0=PC 1=OldPC 2=A 3=0
    logic [1:0] ALUSrcB;     // 0=B 1=ImmExt 2=4 3=0
    logic [2:0] ALUControl;  // 000 ADD 001 SUB 010 AND 011 OR 100 SLT 101 XOR
    logic [2:0] immSrc;      // 000 I 001 S 010 B 011 J 100 U
    logic       halted;      // illegal instruction seen

    modport master (
        input  op, func3, func7, zero, neg,
        output PCWrite, adrSrc, memWrite, IRWrite, regWrite,
               resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, halted
    );

    modport slave (
        output op, func3, func7, zero, neg,
        input  PCWrite, adrSrc, memWrite, IRWrite, regWrite,
               resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, halted
    );
endinterface

// File: rtl/risc_v_multicycle_controller.sv
// Main control FSM of the multicycle RISC-V datapath. One state per cycle;
// controls decode combinationally from the state register (branch PCWrite
// also from zero/neg, EXEC ALU op from func3/func7).
//   clk : system clock, rising edge
//   rst : synchronous active-high reset -> FETCH, clears halted
//   bus : controller side of the controller/datapath bundle
module risc_v_multicycle_controller (
    input  logic                          clk,
    input  logic                          rst,
    risc_v_multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
        S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;

    logic alu_f3_ok, br_f3_ok, br_taken;

    // ALU operation for R/I-type; sub only honoured for R-type
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

    // Legal func3 sets and branch resolution
    always_comb begin
        alu_f3_ok = (bus.func3 == 3'b000) || (bus.func3 == 3'b010) ||
                    (bus.func3 == 3'b100) || (bus.func3 == 3'b110) ||
                    (bus.func3 == 3'b111);
        br_f3_ok  = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
                    (bus.func3 == 3'b100) || (bus.func3 == 3'b101);
        case (bus.func3)
            3'b000:  br_taken = bus.zero;
            3'b001:  br_taken = ~bus.zero;
            3'b100:  br_taken = bus.neg;
            3'b101:  br_taken = ~bus.neg;
            default: br_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next state and control decode
    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        halted      = 1'b0;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                // OldPC+imm lands in ALUOut as branch/jal target
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                if (bus.op == OP_BR)       imm_src = IMM_B;
                else if (bus.op == OP_JAL) imm_src = IMM_J;
                case (bus.op)
                    OP_R:         state_nxt = alu_f3_ok ? S_EXEC_R : S_HALT;
                    OP_I:         state_nxt = alu_f3_ok ? S_EXEC_I : S_HALT;
                    OP_LW, OP_SW: state_nxt = (bus.func3 == 3'b010) ? S_MEM_ADR : S_HALT;
                    OP_BR:        state_nxt = br_f3_ok ? S_BRANCH : S_HALT;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_JALR:      state_nxt = S_JALR;
                    OP_LUI:       state_nxt = S_LUI;
                    default:      state_nxt = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a   = 2'd2;
                alu_control = alu_op(bus.func3, bus.func7);
                state_nxt   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                alu_control = alu_op(bus.func3, 1'b0);
                state_nxt   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (bus.op == OP_SW) ? IMM_S : IMM_I;
                state_nxt = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src   = 1'b1;
                state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'd2;
                alu_control = ALU_SUB;
                pc_write    = br_taken;
                state_nxt   = S_FETCH;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                state_nxt = S_LINK;
            end
            S_JALR: begin
                // rs1 already latched in A, so rd==rs1 is safe
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_nxt  = S_LINK;
            end
            S_LINK: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = 2'd3;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Abandoned instruction must not leave a partial write behind
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.adrSrc     = adr_src;
    assign bus.memWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.regWrite   = reg_write;
    assign bus.resultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.immSrc     = imm_src;
    assign bus.halted     = halted;
endmodule
